// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system-control command decoder: opcodes,
// reserved operand addresses and the parser state encoding.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    // ALU operands live in the register file at these two fixed slots.
    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_OP_A,
        S_OP_B,
        S_ALU_FUN,
        S_ALU_WAIT,
        S_TX_RD,
        S_TX_LO,
        S_TX_HI
    } state_e;

    // First state of the frame started by an opcode byte; unknown bytes stay in IDLE.
    function automatic state_e decode_opcode(input logic [7:0] opcode);
        case (opcode)
            CMD_RF_WR:   return S_WR_ADDR;
            CMD_RF_RD:   return S_RD_ADDR;
            CMD_ALU_OP:  return S_OP_A;
            CMD_ALU_NOP: return S_ALU_FUN;
            default:     return S_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/sys_ctrl_cmd_if.sv
// Bus bundle between the command decoder and its RX / register-file / ALU / TX-FIFO neighbours.
interface sys_ctrl_cmd_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_OUT_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]    RX_DATA;
    logic                     RX_VALID;

    logic                     RF_WrEn;
    logic                     RF_RdEn;
    logic [ADDR_WIDTH-1:0]    RF_Address;
    logic [DATA_WIDTH-1:0]    RF_WrData;
    logic [DATA_WIDTH-1:0]    RF_RdData;
    logic                     RF_RdData_Valid;

    logic                     ALU_EN;
    logic [3:0]               ALU_FUN;
    logic                     CLK_GATE_EN;
    logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
    logic                     ALU_OUT_VALID;

    logic [DATA_WIDTH-1:0]    TX_DATA;
    logic                     TX_VALID;
    logic                     TX_FULL;

    // Decoder side.
    modport slave (
        input  RX_DATA, RX_VALID,
        input  RF_RdData, RF_RdData_Valid,
        input  ALU_OUT, ALU_OUT_VALID,
        input  TX_FULL,
        output RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
        output ALU_EN, ALU_FUN, CLK_GATE_EN,
        output TX_DATA, TX_VALID
    );

    // Surrounding system side.
    modport master (
        output RX_DATA, RX_VALID,
        output RF_RdData, RF_RdData_Valid,
        output ALU_OUT, ALU_OUT_VALID,
        output TX_FULL,
        input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
        input  ALU_EN, ALU_FUN, CLK_GATE_EN,
        input  TX_DATA, TX_VALID
    );

endinterface

// File: rtl/sys_ctrl_cmd.sv
// Framed command decoder: parses RX bytes into register-file and ALU operations
// and pushes read data / ALU results into the TX FIFO. All outputs are registered.
module sys_ctrl_cmd
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_OUT_WIDTH = 16
) (
    input  logic          CLK,
    input  logic          RST,
    sys_ctrl_cmd_if.slave bus
);

    state_e                   state_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [DATA_WIDTH-1:0]    rd_data_q;
    logic [ALU_OUT_WIDTH-1:0] alu_res_q;

    logic                     rf_wren_q;
    logic                     rf_rden_q;
    logic [ADDR_WIDTH-1:0]    rf_addr_q;
    logic [DATA_WIDTH-1:0]    rf_wrdata_q;
    logic                     alu_en_q;
    logic [3:0]               alu_fun_q;
    logic                     clk_gate_q;
    logic [DATA_WIDTH-1:0]    tx_data_q;
    logic                     tx_valid_q;

    state_e                   op_state;
    logic [DATA_WIDTH-1:0]    res_lo;
    logic [DATA_WIDTH-1:0]    res_hi;

    assign op_state = decode_opcode(bus.RX_DATA);
    assign res_lo   = alu_res_q[DATA_WIDTH-1:0];
    assign res_hi   = DATA_WIDTH'(alu_res_q >> DATA_WIDTH);

    // NOTE: every register here is written with <= so all state updates see the
    // pre-edge values; mixing in = would make the result depend on statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rd_data_q   <= '0;
            alu_res_q   <= '0;
            rf_wren_q   <= 1'b0;
            rf_rden_q   <= 1'b0;
            rf_addr_q   <= '0;
            rf_wrdata_q <= '0;
            alu_en_q    <= 1'b0;
            alu_fun_q   <= '0;
            clk_gate_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
        end else begin
            // NOTE: strobes default low each cycle so a single assignment below
            // yields exactly one high cycle without any explicit clearing state.
            rf_wren_q  <= 1'b0;
            rf_rden_q  <= 1'b0;
            alu_en_q   <= 1'b0;
            tx_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bus.RX_VALID) begin
                        state_q <= op_state;
                        if (op_state == S_ALU_FUN) begin
                            clk_gate_q <= 1'b1;
                        end
                    end
                end

                S_WR_ADDR: begin
                    if (bus.RX_VALID) begin
                        addr_q  <= bus.RX_DATA[ADDR_WIDTH-1:0];
                        state_q <= S_WR_DATA;
                    end
                end

                S_WR_DATA: begin
                    if (bus.RX_VALID) begin
                        rf_wren_q   <= 1'b1;
                        rf_addr_q   <= addr_q;
                        rf_wrdata_q <= bus.RX_DATA;
                        state_q     <= S_IDLE;
                    end
                end

                S_RD_ADDR: begin
                    if (bus.RX_VALID) begin
                        rf_rden_q <= 1'b1;
                        rf_addr_q <= bus.RX_DATA[ADDR_WIDTH-1:0];
                        state_q   <= S_RD_WAIT;
                    end
                end

                S_RD_WAIT: begin
                    if (bus.RF_RdData_Valid) begin
                        rd_data_q <= bus.RF_RdData;
                        state_q   <= S_TX_RD;
                    end
                end

                S_TX_RD: begin
                    if (!bus.TX_FULL) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= rd_data_q;
                        state_q    <= S_IDLE;
                    end
                end

                S_OP_A: begin
                    if (bus.RX_VALID) begin
                        rf_wren_q   <= 1'b1;
                        rf_addr_q   <= ADDR_WIDTH'(OPA_ADDR);
                        rf_wrdata_q <= bus.RX_DATA;
                        state_q     <= S_OP_B;
                    end
                end

                S_OP_B: begin
                    if (bus.RX_VALID) begin
                        rf_wren_q   <= 1'b1;
                        rf_addr_q   <= ADDR_WIDTH'(OPB_ADDR);
                        rf_wrdata_q <= bus.RX_DATA;
                        clk_gate_q  <= 1'b1;
                        state_q     <= S_ALU_FUN;
                    end
                end

                S_ALU_FUN: begin
                    if (bus.RX_VALID) begin
                        alu_fun_q <= bus.RX_DATA[3:0];
                        alu_en_q  <= 1'b1;
                        state_q   <= S_ALU_WAIT;
                    end
                end

                // The ALU clock stays enabled until its result has been captured.
                S_ALU_WAIT: begin
                    if (bus.ALU_OUT_VALID) begin
                        alu_res_q  <= bus.ALU_OUT;
                        clk_gate_q <= 1'b0;
                        state_q    <= S_TX_LO;
                    end
                end

                S_TX_LO: begin
                    if (!bus.TX_FULL) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= res_lo;
                        state_q    <= S_TX_HI;
                    end
                end

                S_TX_HI: begin
                    if (!bus.TX_FULL) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= res_hi;
                        state_q    <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.RF_WrEn     = rf_wren_q;
    assign bus.RF_RdEn     = rf_rden_q;
    assign bus.RF_Address  = rf_addr_q;
    assign bus.RF_WrData   = rf_wrdata_q;
    assign bus.ALU_EN      = alu_en_q;
    assign bus.ALU_FUN     = alu_fun_q;
    assign bus.CLK_GATE_EN = clk_gate_q;
    assign bus.TX_DATA     = tx_data_q;
    assign bus.TX_VALID    = tx_valid_q;

endmodule

// File: doc/sys_ctrl_cmd.md
Name: sys_ctrl_cmd

Overview:
- Command decoder that consumes the byte stream leaving the bus synchronizer: `SYNC_BUS` plus its one-cycle `enable_pulse`, mapped here to `RX_DATA` / `RX_VALID`.
- Parses framed commands and issues register-file writes/reads and ALU operations.
- Pushes response bytes into the TX FIFO.
- Lives entirely in the reference (REF_CLK) domain, directly downstream of the data synchronizer.

Parameters:
- DATA_WIDTH, 8: byte width of RX, RF and TX data.
- ADDR_WIDTH, 4: register-file address width; the address byte is truncated to its low ADDR_WIDTH bits.
- ALU_OUT_WIDTH, 16: ALU result width, sent on TX as 2 bytes, LSB first.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- RX_DATA  in  DATA_WIDTH  synchronized byte.
- RX_VALID  in  1  one-cycle strobe, byte valid.
- RF_WrEn  out  1  register-file write strobe.
- RF_RdEn  out  1  register-file read strobe.
- RF_Address  out  ADDR_WIDTH  register-file address.
- RF_WrData  out  DATA_WIDTH  register-file write data.
- RF_RdData  in  DATA_WIDTH  register-file read data.
- RF_RdData_Valid  in  1  read data valid strobe.
- ALU_EN  out  1  ALU start strobe.
- ALU_FUN  out  4  ALU function code.
- CLK_GATE_EN  out  1  ALU clock-gate enable.
- ALU_OUT  in  ALU_OUT_WIDTH  ALU result.
- ALU_OUT_VALID  in  1  ALU result valid strobe.
- TX_DATA  out  DATA_WIDTH  byte to TX FIFO.
- TX_VALID  out  1  TX FIFO write strobe.
- TX_FULL  in  1  TX FIFO full.

Behaviour:
- Reset (RST=0, async):
  - State goes to IDLE.
  - All strobes, RF_Address, RF_WrData, ALU_FUN, TX_DATA, CLK_GATE_EN go to 0.
  - Latched operands go to 0.
- All outputs are registered. Each strobe is high for exactly one cycle, the cycle after the accepting edge.
- Opcodes:
  - 0xAA: RF write, frame = addr, data.
  - 0xBB: RF read, frame = addr.
  - 0xCC: ALU with operands, frame = A, B, fun.
  - 0xDD: ALU without operands, frame = fun.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_RD, TX_LO, TX_HI.
- IDLE:
  - On RX_VALID, decode the byte. 0xAA→WR_ADDR, 0xBB→RD_ADDR, 0xCC→OP_A, 0xDD→ALU_FUN.
  - Any other byte is ignored; stay in IDLE.
- RF write path:
  - WR_ADDR: on RX_VALID, latch addr[ADDR_WIDTH-1:0]; go to WR_DATA.
  - WR_DATA: on RX_VALID, pulse RF_WrEn with the latched address and the byte; go to IDLE.
- RF read path:
  - RD_ADDR: on RX_VALID, pulse RF_RdEn with the address; go to RD_WAIT.
  - RD_WAIT: on RF_RdData_Valid, latch the data; go to TX_RD.
  - TX_RD: when TX_FULL=0, pulse TX_VALID with the data; go to IDLE. While TX_FULL=1, hold.
- ALU with operands:
  - OP_A: on RX_VALID, pulse RF_WrEn at address 0 with the byte; go to OP_B.
  - OP_B: on RX_VALID, pulse RF_WrEn at address 1 with the byte; go to ALU_FUN.
- ALU_FUN:
  - CLK_GATE_EN=1 from entry.
  - On RX_VALID, ALU_FUN←byte[3:0] and pulse ALU_EN; go to ALU_WAIT.
- ALU_WAIT:
  - CLK_GATE_EN stays 1.
  - On ALU_OUT_VALID, latch the result; go to TX_LO.
  - CLK_GATE_EN drops to 0 on leaving ALU_WAIT.
- TX_LO: when TX_FULL=0, send the result's low byte; go to TX_HI.
- TX_HI: when TX_FULL=0, send the result's high byte; go to IDLE.
- Backpressure: TX_VALID is never asserted while TX_FULL=1. The byte is held until TX_FULL falls.
- RX_VALID arriving in RD_WAIT, ALU_WAIT or any TX_* state: the byte is dropped, with no state change.
- RF_RdData_Valid or ALU_OUT_VALID arriving outside its wait state: ignored.
- No timeout. A missing valid response hangs the block until reset.
- Reset asserted mid-frame: immediate return to IDLE; no partial write is issued.
- Back-to-back RX_VALID on consecutive cycles must be accepted with no byte loss in every parse state.

Decomposition:
- Shared package (sys_ctrl_pkg) holds:
  - Opcode constants CMD_RF_WR=0xAA, CMD_RF_RD=0xBB, CMD_ALU_OP=0xCC, CMD_ALU_NOP=0xDD.
  - Reserved addresses OPA_ADDR=0, OPB_ADDR=1.
  - State encoding.
- Single flat module; no sub-module. The TX emit logic is too small to warrant one.

Test Plan:
- RF write: RX 0xAA, 0x05, 0x3C → one RF_WrEn pulse with RF_Address=5, RF_WrData=0x3C; state IDLE.
- RF read: RX 0xBB, 0x05; RF returns 0x3C two cycles after RF_RdEn → exactly one TX_VALID with TX_DATA=0x3C.
- ALU with operands: RX 0xCC, 0x0A, 0x03, 0x00 → RF writes (0,0x0A) then (1,0x03), then ALU_EN with ALU_FUN=0. Return ALU_OUT=0x000D → TX 0x0D then 0x00; CLK_GATE_EN high only from ALU_FUN through ALU_WAIT.
- Backpressure: RX 0xDD, 0x02; ALU_OUT=0x1234 with TX_FULL=1 for 10 cycles → no TX_VALID until TX_FULL falls, then 0x34, 0x12.
- Robustness: RX 0x55 in IDLE → ignored; RX byte during ALU_WAIT → dropped; RST low after 0xAA, 0x05 → no RF_WrEn, all outputs 0, then a fresh 0xAA frame works.
- Back-to-back: RX 0xAA, 0x0F, 0xFF on consecutive cycles → RF_WrEn with RF_Address=0xF, RF_WrData=0xFF.
